// File: rtl/hist_eq_param.sv
// Streaming histogram equaliser: collects frame N's histogram, builds a
// contrast-limited CDF lookup table in the inter-frame gap, remaps frame N+1.
module hist_eq_param #(
    parameter int unsigned DW = 8,
    parameter int unsigned W  = 960,
    parameter int unsigned H  = 540,
    parameter int unsigned CW = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sink_data,
    input  logic          sink_valid,
    input  logic          sink_sop,
    input  logic          sink_eop,
    output logic          sink_ready,
    output logic [DW-1:0] source_data,
    output logic          source_valid,
    output logic          source_sop,
    output logic          source_eop,
    input  logic          source_ready,
    input  logic          clip_en,
    input  logic [CW-1:0] clip_limit,
    input  logic          bypass,
    output logic          lut_ready,
    output logic          frame_err
);

    localparam int unsigned BINS  = 1 << DW;
    localparam int unsigned MAXV  = BINS - 1;
    localparam int unsigned TOTAL = W * H;
    localparam int unsigned AW    = CW + DW;
    localparam int unsigned PW    = AW + DW;
    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
    localparam logic [PW-1:0] TOTAL_P = PW'(TOTAL);
    localparam logic [PW-1:0] MAXV_P  = PW'(MAXV);
    localparam logic [DW-1:0] LAST    = DW'(MAXV);

    typedef enum logic [1:0] {S_CLR, S_RUN, S_DRAIN, S_CDF} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] idx_q, idx_d;
    logic          issue_q, issue_d;
    logic          c1_v_q, c1_v_d;
    logic [DW-1:0] c1_idx_q, c1_idx_d;
    logic [CW-1:0] c1_h_q, c1_h_d;
    logic          c2_v_q, c2_v_d;
    logic [DW-1:0] c2_idx_q, c2_idx_d;
    logic [AW-1:0] cdf_q, cdf_d;
    logic          clip_en_q, clip_en_d;
    logic [CW-1:0] clip_lim_q, clip_lim_d;
    logic          hp1_v_q, hp1_v_d;
    logic [DW-1:0] hp1_pix_q, hp1_pix_d;
    logic          hp2_v_q, hp2_v_d;
    logic [DW-1:0] hp2_pix_q, hp2_pix_d;
    logic [CW-1:0] hp2_cnt_q, hp2_cnt_d;
    logic          s1_v_q, s1_v_d;
    logic [DW-1:0] s1_pix_q, s1_pix_d;
    logic          s1_sop_q, s1_sop_d;
    logic          s1_eop_q, s1_eop_d;
    logic          src_valid_q, src_valid_d;
    logic [DW-1:0] src_data_q, src_data_d;
    logic          src_sop_q, src_sop_d;
    logic          src_eop_q, src_eop_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic          frame_err_q, frame_err_d;
    logic          lut_ready_q, lut_ready_d;
    logic          eop_gone_q, eop_gone_d;

    logic [CW-1:0] hist_mem [BINS];
    logic [DW-1:0] lut_mem  [BINS];

    logic          advance, ready_c, accept, gone;
    logic [DW-1:0] hist_ra;
    logic [CW-1:0] hist_rd, rd_fwd, new_cnt;
    logic          hist_we;
    logic [DW-1:0] hist_wa;
    logic [CW-1:0] hist_wd;
    logic          lut_we;
    logic [DW-1:0] lut_wa, lut_wd;
    logic [PW-1:0] prod, quot;

    assign sink_ready   = ready_c;
    assign source_data  = src_data_q;
    assign source_valid = src_valid_q;
    assign source_sop   = src_sop_q;
    assign source_eop   = src_eop_q;
    assign lut_ready    = lut_ready_q;
    assign frame_err    = frame_err_q;

    always_comb begin
        advance = !src_valid_q || source_ready;
        ready_c = (state_q == S_RUN) && advance;
        accept  = sink_valid && ready_c;
        hist_ra = (state_q == S_CDF) ? idx_q : hp1_pix_q;
        hist_rd = hist_mem[hist_ra];
        gone    = eop_gone_q || (src_valid_q && source_ready && src_eop_q);
        new_cnt = pix_cnt_q;

        state_d     = state_q;
        idx_d       = idx_q;
        issue_d     = issue_q;
        c1_v_d      = 1'b0;
        c1_idx_d    = c1_idx_q;
        c1_h_d      = c1_h_q;
        c2_v_d      = 1'b0;
        c2_idx_d    = c2_idx_q;
        cdf_d       = cdf_q;
        clip_en_d   = clip_en_q;
        clip_lim_d  = clip_lim_q;
        s1_v_d      = s1_v_q;
        s1_pix_d    = s1_pix_q;
        s1_sop_d    = s1_sop_q;
        s1_eop_d    = s1_eop_q;
        src_valid_d = src_valid_q;
        src_data_d  = src_data_q;
        src_sop_d   = src_sop_q;
        src_eop_d   = src_eop_q;
        pix_cnt_d   = pix_cnt_q;
        frame_err_d = 1'b0;
        lut_ready_d = lut_ready_q;
        eop_gone_d  = eop_gone_q;

        // Both data stages move together, so a stalled output freezes the pipe.
        if (advance) begin
            src_valid_d = s1_v_q;
            src_sop_d   = s1_v_q && s1_sop_q;
            src_eop_d   = s1_v_q && s1_eop_q;
            if (s1_v_q) begin
                src_data_d = (bypass || !lut_ready_q) ? s1_pix_q : lut_mem[s1_pix_q];
            end
            s1_v_d = accept;
            if (accept) begin
                s1_pix_d = sink_data;
                s1_sop_d = sink_sop;
                s1_eop_d = sink_eop;
            end
        end

        // Forward the count being written this cycle to a back-to-back hit.
        hp1_v_d   = accept;
        hp1_pix_d = accept ? sink_data : hp1_pix_q;
        rd_fwd    = (hp2_v_q && (hp2_pix_q == hp1_pix_q)) ? hp2_cnt_q : hist_rd;
        hp2_v_d   = hp1_v_q;
        hp2_pix_d = hp1_pix_q;
        hp2_cnt_d = (rd_fwd == '1) ? rd_fwd : rd_fwd + CW'(1);

        if (accept) begin
            if (sink_sop) begin
                new_cnt = CW'(1);
            end else if (pix_cnt_q != '1) begin
                new_cnt = pix_cnt_q + CW'(1);
            end
            pix_cnt_d = new_cnt;
            if (sink_eop) begin
                frame_err_d = (new_cnt != TOTAL_C);
            end
        end

        hist_we = 1'b0;
        hist_wa = hp2_pix_q;
        hist_wd = hp2_cnt_q;

        case (state_q)
            S_CLR: begin
                hist_we = 1'b1;
                hist_wa = idx_q;
                hist_wd = '0;
                idx_d   = idx_q + DW'(1);
                if (idx_q == LAST) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                hist_we = hp2_v_q;
                if (accept && sink_eop) begin
                    state_d    = S_DRAIN;
                    eop_gone_d = 1'b0;
                end
            end
            S_DRAIN: begin
                hist_we    = hp2_v_q;
                eop_gone_d = gone;
                if (gone && !hp1_v_q && !hp2_v_q) begin
                    state_d    = S_CDF;
                    idx_d      = '0;
                    issue_d    = 1'b1;
                    cdf_d      = '0;
                    clip_en_d  = clip_en;
                    clip_lim_d = clip_limit;
                end
            end
            default: begin
                if (issue_q) begin
                    idx_d = idx_q + DW'(1);
                    if (idx_q == LAST) begin
                        issue_d = 1'b0;
                    end
                end
                c1_v_d   = issue_q;
                c1_idx_d = idx_q;
                c1_h_d   = (clip_en_q && (hist_rd > clip_lim_q)) ? clip_lim_q : hist_rd;
                c2_v_d   = c1_v_q;
                c2_idx_d = c1_idx_q;
                if (c1_v_q) begin
                    cdf_d   = cdf_q + AW'(c1_h_q);
                    hist_we = 1'b1;
                    hist_wa = c1_idx_q;
                    hist_wd = '0;
                end
                if (c2_v_q && (c2_idx_q == LAST)) begin
                    state_d     = S_RUN;
                    lut_ready_d = 1'b1;
                end
            end
        endcase

        prod   = PW'(cdf_q) * MAXV_P;
        quot   = prod / TOTAL_P;
        lut_we = c2_v_q;
        lut_wa = c2_idx_q;
        lut_wd = (quot > MAXV_P) ? LAST : quot[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_CLR;
            idx_q       <= '0;
            issue_q     <= 1'b0;
            c1_v_q      <= 1'b0;
            c1_idx_q    <= '0;
            c1_h_q      <= '0;
            c2_v_q      <= 1'b0;
            c2_idx_q    <= '0;
            cdf_q       <= '0;
            clip_en_q   <= 1'b0;
            clip_lim_q  <= '0;
            hp1_v_q     <= 1'b0;
            hp1_pix_q   <= '0;
            hp2_v_q     <= 1'b0;
            hp2_pix_q   <= '0;
            hp2_cnt_q   <= '0;
            s1_v_q      <= 1'b0;
            s1_pix_q    <= '0;
            s1_sop_q    <= 1'b0;
            s1_eop_q    <= 1'b0;
            src_valid_q <= 1'b0;
            src_data_q  <= '0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            pix_cnt_q   <= '0;
            frame_err_q <= 1'b0;
            lut_ready_q <= 1'b0;
            eop_gone_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            issue_q     <= issue_d;
            c1_v_q      <= c1_v_d;
            c1_idx_q    <= c1_idx_d;
            c1_h_q      <= c1_h_d;
            c2_v_q      <= c2_v_d;
            c2_idx_q    <= c2_idx_d;
            cdf_q       <= cdf_d;
            clip_en_q   <= clip_en_d;
            clip_lim_q  <= clip_lim_d;
            hp1_v_q     <= hp1_v_d;
            hp1_pix_q   <= hp1_pix_d;
            hp2_v_q     <= hp2_v_d;
            hp2_pix_q   <= hp2_pix_d;
            hp2_cnt_q   <= hp2_cnt_d;
            s1_v_q      <= s1_v_d;
            s1_pix_q    <= s1_pix_d;
            s1_sop_q    <= s1_sop_d;
            s1_eop_q    <= s1_eop_d;
            src_valid_q <= src_valid_d;
            src_data_q  <= src_data_d;
            src_sop_q   <= src_sop_d;
            src_eop_q   <= src_eop_d;
            pix_cnt_q   <= pix_cnt_d;
            frame_err_q <= frame_err_d;
            lut_ready_q <= lut_ready_d;
            eop_gone_q  <= eop_gone_d;
        end
    end

    always_ff @(posedge clk) begin
        if (hist_we) begin
            hist_mem[hist_wa] <= hist_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_mem[lut_wa] <= lut_wd;
        end
    end

endmodule

// File: tb/tb_hist_eq_param.sv
// Bench for hist_eq_param: small frames, randomized pixels/stalls, checked
// against a frame-level histogram/CDF reference model.
module tb_hist_eq_param;

    localparam int DW  = 8;
    localparam int W   = 4;
    localparam int H   = 2;
    localparam int CW  = 21;
    localparam int TOT = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] sink_data;
    logic          sink_valid, sink_sop, sink_eop, sink_ready;
    logic [DW-1:0] source_data;
    logic          source_valid, source_sop, source_eop;
    logic          source_ready;
    logic          clip_en;
    logic [CW-1:0] clip_limit;
    logic          bypass, lut_ready, frame_err;

    hist_eq_param #(.DW(DW), .W(W), .H(H), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_ready(sink_ready),
        .source_data(source_data), .source_valid(source_valid),
        .source_sop(source_sop), .source_eop(source_eop), .source_ready(source_ready),
        .clip_en(clip_en), .clip_limit(clip_limit), .bypass(bypass),
        .lut_ready(lut_ready), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int         m_hist[256];
    int         m_lut[256];
    bit         m_lut_rdy;
    int         m_cnt;
    int         exp_err, obs_err;
    logic [9:0] exp_q[$];
    logic [9:0] e;
    int         blk;
    bit         blk_viol;
    bit         hold_v;
    logic [9:0] hold_val;
    bit         stall, aborted;

    task automatic model_accept(input logic [7:0] d, input logic s, input logic eo);
        logic [7:0] p;
        int cdf, h, v;
        p = (bypass || !m_lut_rdy) ? d : 8'(m_lut[d]);
        exp_q.push_back({p, s, eo});
        m_hist[d]++;
        m_cnt = s ? 1 : m_cnt + 1;
        if (eo) begin
            if (m_cnt != TOT) exp_err++;
            cdf = 0;
            for (int i = 0; i < 256; i++) begin
                h = m_hist[i];
                if (clip_en && h > int'(clip_limit)) h = int'(clip_limit);
                cdf += h;
                v = cdf * 255 / TOT;
                m_lut[i] = (v > 255) ? 255 : v;
                m_hist[i] = 0;
            end
            m_lut_rdy = 1'b1;
            blk = 256;
            blk_viol = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            for (int i = 0; i < 256; i++) m_hist[i] = 0;
            m_cnt = 0;
            m_lut_rdy = 1'b0;
            blk = 0;
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                check("stall_hold", 32'({source_valid, source_data, source_sop, source_eop}),
                      32'({1'b1, hold_val}));
            hold_v = source_valid && !source_ready;
            hold_val = {source_data, source_sop, source_eop};
            if (source_valid && source_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_out", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out", 32'({source_data, source_sop, source_eop}), 32'(e));
                end
            end
            if (frame_err) obs_err++;
            if (blk > 0) begin
                if (sink_ready) blk_viol = 1'b1;
                blk--;
                if (blk == 0) check("ready_low_gap", 32'(blk_viol), 32'(0));
            end
            if (sink_valid && sink_ready) model_accept(sink_data, sink_sop, sink_eop);
        end
    end

    initial begin
        source_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            source_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_pix(input logic [7:0] d, input logic s, input logic eo, input int gap);
        bit acc;
        int t;
        if (aborted) return;
        sink_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        sink_data = d;
        sink_sop = s;
        sink_eop = eo;
        sink_valid = 1'b1;
        acc = 1'b0;
        t = 0;
        while (!acc && !aborted) begin
            @(negedge clk);
            if (sink_ready) begin
                acc = 1'b1;
            end else begin
                t++;
                if (t > 2000) begin
                    check("accept_timeout", 32'(0), 32'(1));
                    aborted = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        sink_valid = 1'b0;
        sink_sop = 1'b0;
        sink_eop = 1'b0;
    endtask

    // kind 0: constant val, 1: ramp, 2: random in 0..val
    task automatic send_frame(input int kind, input int val, input int n, input bit gaps);
        logic [7:0] d;
        int gap;
        for (int i = 0; i < n; i++) begin
            d = (kind == 0) ? 8'(val) : (kind == 1) ? 8'(i) : 8'($urandom_range(0, val));
            gap = (gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_pix(d, i == 0, i == n - 1, gap);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!aborted && !(exp_q.size() == 0 && sink_ready === 1'b1)) begin
            @(negedge clk);
            t++;
            if (t > 5000) begin
                check("idle_timeout", 32'(0), 32'(1));
                aborted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int e0;

    initial begin
        rst = 1'b0;
        sink_data = '0;
        sink_valid = 1'b0;
        sink_sop = 1'b0;
        sink_eop = 1'b0;
        clip_en = 1'b0;
        clip_limit = '0;
        bypass = 1'b0;
        stall = 1'b0;
        aborted = 1'b0;
        exp_err = 0;
        obs_err = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_source_valid", 32'(source_valid), 32'(0));
        check("rst_source_sop", 32'(source_sop), 32'(0));
        check("rst_source_eop", 32'(source_eop), 32'(0));
        check("rst_source_data", 32'(source_data), 32'(0));
        check("rst_sink_ready", 32'(sink_ready), 32'(0));
        check("rst_lut_ready", 32'(lut_ready), 32'(0));
        check("rst_frame_err", 32'(frame_err), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_idle();
        check("lut_ready_initial", 32'(lut_ready), 32'(m_lut_rdy));

        // Constant frames: pass-through, then all map to the top level
        send_frame(0, 10, TOT, 1'b0);
        wait_idle();
        check("lut_ready_after_first", 32'(lut_ready), 32'(m_lut_rdy));
        send_frame(0, 10, TOT, 1'b0);
        wait_idle();

        // Ramp frames
        send_frame(1, 0, TOT, 1'b0);
        wait_idle();
        send_frame(1, 0, TOT, 1'b0);
        wait_idle();

        // Clip limit
        clip_en = 1'b1;
        clip_limit = 21'd2;
        send_frame(0, 10, TOT, 1'b0);
        wait_idle();
        send_frame(0, 10, TOT, 1'b0);
        wait_idle();
        clip_en = 1'b0;

        // Random backpressure on ramps
        stall = 1'b1;
        send_frame(1, 0, TOT, 1'b0);
        wait_idle();
        send_frame(1, 0, TOT, 1'b0);
        wait_idle();
        stall = 1'b0;

        // Short frame then a correct one
        e0 = obs_err;
        send_frame(1, 0, TOT - 1, 1'b0);
        wait_idle();
        check("err_short_frame", 32'(obs_err - e0), 32'(1));
        send_frame(1, 0, TOT, 1'b0);
        wait_idle();
        check("err_clean_frame", 32'(obs_err - e0), 32'(1));

        // Reset mid-frame, leftover pixels must not reach the new histogram
        send_pix(8'd2, 1'b1, 1'b0, 0);
        send_pix(8'd2, 1'b0, 1'b0, 0);
        send_pix(8'd2, 1'b0, 1'b0, 0);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        wait_idle();
        check("lut_ready_after_reset", 32'(lut_ready), 32'(m_lut_rdy));
        send_frame(1, 0, TOT, 1'b0);
        wait_idle();
        check("lut_ready_rebuilt", 32'(lut_ready), 32'(m_lut_rdy));
        send_frame(0, 5, TOT, 1'b0);
        wait_idle();

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            stall = ($urandom_range(0, 1) == 1);
            bypass = ($urandom_range(0, 3) == 0);
            clip_en = ($urandom_range(0, 1) == 1);
            clip_limit = 21'($urandom_range(1, 4));
            send_frame(2, ($urandom_range(0, 2) == 0) ? 255 : 15,
                       ($urandom_range(0, 4) == 0) ? TOT - 1 : TOT, 1'b1);
            wait_idle();
        end
        stall = 1'b0;
        bypass = 1'b0;

        check("err_total", 32'(obs_err), 32'(exp_err));
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
